// File: rtl/uart_pkg.sv
// Shared encodings and line levels for the memory-to-UART transmit path.
// Imported by the control block and the serial core.
package uart_pkg;

  typedef enum logic [2:0] {
    C_IDLE,
    C_FETCH,
    C_LATCH,
    C_SEND,
    C_NEXT
  } ctrl_state_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } ser_state_t;

  localparam logic UART_IDLE_LVL = 1'b1;
  localparam logic START_BIT     = 1'b0;
  localparam logic STOP_BIT      = 1'b1;
  localparam int   FRAME_BITS    = 10;

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serial transmitter: one start bit, D_WIDTH data bits LSB first,
// one stop bit; frame_done pulses in the last stop-bit cycle.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int D_WIDTH      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tx_start,
  input  logic [D_WIDTH-1:0] tx_data,
  output logic               tx,
  output logic               frame_done
);

  localparam int BW   = $clog2(CLKS_PER_BIT);
  localparam int BITW = $clog2(D_WIDTH);

  ser_state_t         state, state_nx;
  logic [BW-1:0]      baud;
  logic [BITW-1:0]    bit_idx;
  logic [D_WIDTH-1:0] shreg;
  logic               baud_end;

  assign baud_end = (baud == BW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_nx   = state;
    frame_done = 1'b0;
    tx         = UART_IDLE_LVL;
    unique case (state)
      S_IDLE: begin
        if (tx_start) state_nx = S_START;
      end
      S_START: begin
        tx = START_BIT;
        if (baud_end) state_nx = S_DATA;
      end
      S_DATA: begin
        tx = shreg[0];
        if (baud_end && bit_idx == BITW'(D_WIDTH - 1))
          state_nx = S_STOP;
      end
      S_STOP: begin
        tx = STOP_BIT;
        if (baud_end) begin
          state_nx   = S_IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE) begin
        baud <= '0;
        if (tx_start) shreg <= tx_data;
      end else begin
        baud <= baud_end ? '0 : baud + 1'b1;
      end
      if (state != S_DATA) begin
        bit_idx <= '0;
      end else if (baud_end) begin
        bit_idx <= bit_idx + 1'b1;
        shreg   <= shreg >> 1;
      end
    end
  end

endmodule

// File: rtl/mem_uart_tx.sv
// Burst reader: on push_send, streams memory bytes 0..wr_count-1
// out over UART, one fetch/latch/send/next round per byte.
module mem_uart_tx
  import uart_pkg::*;
#(
  parameter int D_WIDTH      = 8,
  parameter int A_WIDTH      = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_send,
  input  logic [A_WIDTH:0]   wr_count,
  output logic               mem_rd_en,
  output logic [A_WIDTH-1:0] mem_rd_addr,
  input  logic [D_WIDTH-1:0] mem_rd_data,
  output logic               tx,
  output logic               tx_busy,
  output logic               tx_done,
  output logic [A_WIDTH:0]   sent_count
);

  ctrl_state_t      state, state_nx;
  logic [A_WIDTH:0] burst_len;
  logic [A_WIDTH:0] index;
  logic             tx_start;
  logic             frame_done;
  logic             last;

  // index tracks sent_count, so it also serves the end-of-burst test
  assign last        = ((index + 1'b1) == burst_len);
  assign mem_rd_addr = index[A_WIDTH-1:0];
  assign tx_busy     = (state != C_IDLE);

  always_comb begin
    state_nx  = state;
    mem_rd_en = 1'b0;
    tx_start  = 1'b0;
    tx_done   = 1'b0;
    unique case (state)
      C_IDLE: begin
        if (push_send && wr_count != '0)
          state_nx = C_FETCH;
      end
      C_FETCH: begin
        mem_rd_en = 1'b1;
        state_nx  = C_LATCH;
      end
      C_LATCH: begin
        tx_start = 1'b1;
        state_nx = C_SEND;
      end
      C_SEND: begin
        if (frame_done) state_nx = C_NEXT;
      end
      C_NEXT: begin
        if (last) begin
          tx_done  = 1'b1;
          state_nx = C_IDLE;
        end else begin
          state_nx = C_FETCH;
        end
      end
      default: state_nx = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= C_IDLE;
      burst_len  <= '0;
      index      <= '0;
      sent_count <= '0;
    end else begin
      state <= state_nx;
      if (state == C_IDLE && state_nx == C_FETCH) begin
        burst_len  <= wr_count;
        index      <= '0;
        sent_count <= '0;
      end else if (state == C_NEXT) begin
        index      <= index + 1'b1;
        sent_count <= sent_count + 1'b1;
      end
    end
  end

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .D_WIDTH     (D_WIDTH)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .tx_start  (tx_start),
    .tx_data   (mem_rd_data),
    .tx        (tx),
    .frame_done(frame_done)
  );

endmodule

// File: tb/tb_mem_uart_tx.sv
// Randomized bench for mem_uart_tx: a per-cycle expected-output queue
// built from the burst rules, plus a serial decoder and literal pins.
module tb_mem_uart_tx;

  localparam int CPB = 16;
  localparam int AW  = 4;
  localparam int DW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          push_send;
  logic [AW:0]   wr_count;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic          tx;
  logic          tx_busy;
  logic          tx_done;
  logic [AW:0]   sent_count;

  mem_uart_tx #(
    .D_WIDTH(DW), .A_WIDTH(AW), .CLKS_PER_BIT(CPB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .push_send  (push_send),
    .wr_count   (wr_count),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .sent_count (sent_count)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [16];
  always @(posedge clk)
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  typedef struct {
    int tx; int busy; int done; int rd; int addr; int sent;
  } exp_t;

  exp_t expq[$];
  int   cur_busy = 0;
  int   held_sent = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   chk_en = 1'b0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   push_cyc = 0;
  int   rxq[$];
  int   rx_starts[$];
  int   rx_s = -1;
  logic [7:0] rx_b;

  function automatic exp_t mk(int t, int b, int d, int r, int a, int s);
    exp_t e;
    e.tx = t; e.busy = b; e.done = d; e.rd = r; e.addr = a; e.sent = s;
    return e;
  endfunction

  // Expected waveform of a whole burst, one entry per clock cycle
  function automatic void sched(int len);
    logic [7:0] b;
    int bit_v;
    for (int i = 0; i < len; i++) begin
      b = mem[i];
      expq.push_back(mk(1, 1, 0, 1, i, i));
      expq.push_back(mk(1, 1, 0, 0, 0, i));
      for (int k = 0; k < 10; k++) begin
        if (k == 0) bit_v = 0;
        else if (k == 9) bit_v = 1;
        else bit_v = int'(b[k-1]);
        repeat (CPB) expq.push_back(mk(bit_v, 1, 0, 0, 0, i));
      end
      expq.push_back(mk(1, 1, (i == len - 1) ? 1 : 0, 0, 0, i));
    end
  endfunction

  task automatic lit(input string name, input int act, input int exp_v);
    vectors++;
    if (act != exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp_v);
    end
  endtask

  function automatic int qat(int i);
    return (rxq.size() > i) ? rxq[i] : -1;
  endfunction

  function automatic int sat(int i);
    return (rx_starts.size() > i) ? rx_starts[i] : -1000;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    logic ok;
    #1;
    cyc++;
    if (chk_en) begin
      e = (expq.size() != 0) ? expq.pop_front()
                             : mk(1, 0, 0, 0, 0, held_sent);
      cur_busy = e.busy;
      if (e.done != 0) held_sent = e.sent + 1;
      ok = (tx === e.tx[0]) && (tx_busy === e.busy[0]) &&
           (tx_done === e.done[0]) && (mem_rd_en === e.rd[0]) &&
           (sent_count === e.sent[AW:0]) &&
           (e.rd == 0 || mem_rd_addr === e.addr[AW-1:0]);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL cyc %0d tx/busy/done/rd addr sent: got %b%b%b%b %0d %0d want %0d%0d%0d%0d %0d %0d",
                 cyc, tx, tx_busy, tx_done, mem_rd_en, mem_rd_addr,
                 sent_count, e.tx, e.busy, e.done, e.rd, e.addr, e.sent);
      end
      if (tx_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (rst === 1'b1) begin
        rx_s = -1;
      end else if (rx_s < 0) begin
        if (tx === 1'b0) begin
          rx_s = 0;
          rx_starts.push_back(cyc);
        end
      end else begin
        rx_s++;
        if (rx_s >= 24 && rx_s <= 136 && (rx_s - 24) % 16 == 0)
          rx_b[(rx_s - 24) / 16] = tx;
        if (rx_s == 159) begin
          rxq.push_back(int'(rx_b));
          rx_s = -1;
        end
      end
    end
  end

  task automatic model_step();
    if (rst) begin
      expq.delete();
      held_sent = 0;
      cur_busy  = 0;
    end else if (push_send && cur_busy == 0 && wr_count != 0) begin
      sched(int'(wr_count));
      push_cyc = cyc;
    end
  endtask

  task automatic drive(input bit p, input bit r);
    @(negedge clk);
    push_send = p;
    rst       = r;
    model_step();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      drive(1'b0, 1'b0);
      n++;
    end while ((cur_busy != 0 || expq.size() != 0) && n < budget);
    lit("burst_timeout", (n >= budget) ? 1 : 0, 0);
    idle(2);
  endtask

  task automatic clr_rx();
    rxq.delete();
    rx_starts.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int len;
    rst       = 1'b1;
    push_send = 1'b0;
    wr_count  = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    drive(1'b0, 1'b1);
    chk_en = 1'b1;
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    idle(200);
    lit("reset_no_done", done_cnt, 0);
    lit("reset_no_frames", rx_starts.size(), 0);
    lit("reset_tx_high", int'(tx), 1);

    clr_rx();
    mem[0]   = 8'h63;
    wr_count = 5'd1;
    drive(1'b1, 1'b0);
    wait_done(400);
    lit("single_frames", rxq.size(), 1);
    lit("single_byte", qat(0), 'h63);
    lit("single_start_lat", sat(0) - push_cyc, 3);
    lit("single_done_lat", done_cyc - push_cyc, 163);
    lit("single_sent", int'(sent_count), 1);

    clr_rx();
    mem[0] = 8'h63; mem[1] = 8'h35; mem[2] = 8'h20;
    wr_count = 5'd3;
    drive(1'b1, 1'b0);
    wait_done(800);
    lit("three_frames", rxq.size(), 3);
    lit("three_b0", qat(0), 'h63);
    lit("three_b1", qat(1), 'h35);
    lit("three_b2", qat(2), 'h20);
    lit("three_gap", sat(1) - sat(0), 163);
    lit("three_done_lat", done_cyc - push_cyc, 489);
    lit("three_sent", int'(sent_count), 3);

    clr_rx();
    d0 = done_cnt;
    wr_count = 5'd0;
    drive(1'b1, 1'b0);
    idle(50);
    lit("zero_len_done", done_cnt - d0, 0);
    lit("zero_len_frames", rx_starts.size(), 0);
    wr_count = 5'd3;
    drive(1'b1, 1'b0);
    idle(100);
    drive(1'b1, 1'b0);
    wait_done(800);
    lit("repush_frames", rxq.size(), 3);
    lit("repush_done", done_cnt - d0, 1);

    clr_rx();
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    wr_count = 5'd16;
    drive(1'b1, 1'b0);
    idle(500);
    wr_count = 5'd16;
    wait_done(3000);
    lit("full_frames", rxq.size(), 16);
    for (int i = 0; i < 16; i++) lit("full_byte", qat(i), i);
    lit("full_sent", int'(sent_count), 16);

    clr_rx();
    wr_count = 5'd2;
    drive(1'b1, 1'b0);
    idle(50);
    wr_count = 5'd5;
    wait_done(800);
    lit("snap_frames", rxq.size(), 2);
    lit("snap_sent", int'(sent_count), 2);

    for (int r = 0; r < 6; r++) begin
      clr_rx();
      len = $urandom_range(1, 16);
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      wr_count = 5'(len);
      drive(1'b1, 1'b0);
      idle($urandom_range(1, len * 150));
      wr_count = 5'($urandom_range(0, 16));
      drive(1'b1, 1'b0);
      wait_done(3000);
      lit("rand_frames", rxq.size(), len);
      for (int i = 0; i < len; i++) lit("rand_byte", qat(i), int'(mem[i]));
    end

    clr_rx();
    mem[0]   = 8'h35;
    wr_count = 5'd1;
    drive(1'b1, 1'b0);
    idle(88);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    lit("midrst_tx", int'(tx), 1);
    lit("midrst_busy", int'(tx_busy), 0);
    idle(20);
    lit("midrst_no_frame", rxq.size(), 0);
    clr_rx();
    mem[0] = 8'h63;
    drive(1'b1, 1'b0);
    wait_done(400);
    lit("restart_frames", rxq.size(), 1);
    lit("restart_byte", qat(0), 'h63);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
